// File: rtl/dmem_stall_ctrl.sv
// Data-memory stage behind the core's data port.
// Reads are returned after RD_LAT cycles with stall held high in the meantime.
// Writes are posted through a one-entry buffer that drains after WR_LAT cycles.
// The rst_n input is an active-high synchronous clear, despite its name.
module dmem_stall_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Data2Mem,
  output logic [DATA_W-1:0] ReadDataMem,
  output logic              stall
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [2:0] RD_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
  localparam logic [2:0] WR_LOAD = (WR_LAT > 0) ? 3'(WR_LAT - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] rdata_q;

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [2:0]        wcnt;

  logic is_wr;
  logic is_rd;
  logic commit;
  logic rd_start;
  logic wr_accept;

  // Request decode; OEN is a don't-care for writes.
  assign is_wr  = ~CEN & ~WEN;
  assign is_rd  = ~CEN & WEN & ~OEN;
  assign commit = buf_valid & (wcnt == 3'd0);

  // A read may only begin once the buffered write has fully drained (no forwarding).
  assign rd_start  = (state == IDLE) & is_rd & ~buf_valid & (RD_LAT != 0);
  // A write is taken when the buffer is free or is emptying this very cycle.
  assign wr_accept = (state == IDLE) & is_wr & (~buf_valid | commit);

  // Zero read latency bypasses the FSM and returns the array word combinationally.
  assign ReadDataMem = (RD_LAT == 0) ? mem[A] : rdata_q;

  // Stall decision for the request currently presented by the core.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE: begin
        if (is_wr) begin
          stall = buf_valid & ~commit;
        end else if (is_rd) begin
          stall = buf_valid | (RD_LAT != 0);
        end
      end
      RD_WAIT: stall = 1'b1;
      RD_DONE: stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Read FSM: capture the word on entry, count down, present it for one cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_start) begin
            rdata_q <= mem[A];
            cnt     <= RD_LOAD;
            state   <= (RD_LAT == 1) ? RD_DONE : RD_WAIT;
          end
        end
        RD_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state <= RD_DONE;
          end
        end
        RD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write buffer and array update; the array is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      wcnt      <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (WR_LAT == 0) begin
      if (wr_accept) begin
        mem[A] <= Data2Mem;
      end
    end else begin
      if (commit) begin
        mem[buf_addr] <= buf_data;
      end
      if (wr_accept) begin
        buf_valid <= 1'b1;
        buf_addr  <= A;
        buf_data  <= Data2Mem;
        wcnt      <= WR_LOAD;
      end else if (commit) begin
        buf_valid <= 1'b0;
      end else if (buf_valid) begin
        wcnt <= wcnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Scoreboard bench for dmem_stall_ctrl: a latency-2 instance driven with
// directed and random traffic, plus a zero-latency instance.
module tb_dmem_stall_ctrl;

  localparam int RL = 2;
  localparam int WL = 2;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    longint      cyc;
    logic [6:0]  addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;
  logic        stall;

  logic        cen0, wen0, oen0;
  logic [6:0]  a0;
  logic [31:0] d0;
  logic [31:0] rdata0;
  logic        stall0;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  exp_t        q[$];
  logic [31:0] q0[$];

  // Reference model: array contents plus the cycle in which the pending write commits.
  logic [31:0] mdl [128];
  logic [31:0] mdl0 [128];
  longint      commit_t;

  dmem_stall_ctrl #(.ADDR_W(7), .DATA_W(32), .RD_LAT(RL), .WR_LAT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
    .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem), .stall(stall)
  );

  dmem_stall_ctrl #(.ADDR_W(7), .DATA_W(32), .RD_LAT(0), .WR_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .CEN(cen0), .WEN(wen0), .OEN(oen0), .A(a0),
    .Data2Mem(d0), .ReadDataMem(rdata0), .stall(stall0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Monitor for the latency-2 instance: a request with stall low is a completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n == 1'b0) begin
      if (!CEN && (!WEN || !OEN)) begin
        if (!stall) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: cyc=%0d got completion required none", cyc);
          end else begin
            e = q.pop_front();
            if (cyc != e.cyc) begin
              errors++;
              $display("FAIL done_cycle: a=%0d got cyc=%0d required cyc=%0d", e.addr, cyc, e.cyc);
            end
            if (e.is_rd) begin
              checks++;
              if (ReadDataMem !== e.data) begin
                errors++;
                $display("FAIL rdata: a=%0d got %h required %h", e.addr, ReadDataMem, e.data);
              end
            end
            $display("%s a=%0d data=%h cyc=%0d", e.is_rd ? "rd" : "wr", e.addr,
                     e.is_rd ? ReadDataMem : e.data, cyc);
          end
        end
      end else begin
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL noop_stall: cyc=%0d got stall=%b required 0", cyc, stall);
        end
      end
    end
  end

  // Monitor for the zero-latency instance: never stalls, reads are combinational.
  always @(negedge clk) begin
    logic [31:0] ex;
    if (rst_n == 1'b0 && !cen0 && (!wen0 || !oen0)) begin
      checks++;
      if (stall0 !== 1'b0) begin
        errors++;
        $display("FAIL zl_stall: cyc=%0d got stall=%b required 0", cyc, stall0);
      end
      if (wen0 && !oen0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL zl_unexpected_read: cyc=%0d got read required none", cyc);
        end else begin
          ex = q0.pop_front();
          if (rdata0 !== ex) begin
            errors++;
            $display("FAIL zl_rdata: a=%0d got %h required %h", a0, rdata0, ex);
          end
          $display("zl rd a=%0d data=%h cyc=%0d", a0, rdata0, cyc);
        end
      end else begin
        $display("zl wr a=%0d data=%h cyc=%0d", a0, d0, cyc);
      end
    end
  end

  task automatic set_noop();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
    cen0 = 1'b1; wen0 = 1'b1; oen0 = 1'b1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 128; i++) begin
      mdl[i]  = '0;
      mdl0[i] = '0;
    end
    commit_t = -100;
  endtask

  // One-cycle reset pulse; called just after a rising edge.
  task automatic do_reset();
    set_noop();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
  endtask

  // kind: 0 = CEN high noop, 1 = CEN low / WEN=OEN=1 noop, 2 = write, 3 = read.
  task automatic issue(input int kind, input logic [6:0] a, input logic [31:0] d);
    exp_t   e;
    longint t;
    longint st;
    int     n;
    bit     done;
    t = cyc;
    A = a;
    Data2Mem = d;
    case (kind)
      0: begin CEN = 1'b1; WEN = 1'b0; OEN = 1'b0; end
      1: begin CEN = 1'b0; WEN = 1'b1; OEN = 1'b1; end
      2: begin CEN = 1'b0; WEN = 1'b0; OEN = 1'($urandom_range(0, 1)); end
      default: begin CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; end
    endcase
    if (kind < 2) begin
      @(posedge clk);
      #1;
      set_noop();
      return;
    end
    if (kind == 2) begin
      st = (t > commit_t) ? t : commit_t;
      commit_t = st + WL;
      mdl[a] = d;
      e = '{is_rd: 1'b0, data: d, cyc: st, addr: a};
    end else begin
      st = (t > commit_t) ? t : commit_t + 1;
      e = '{is_rd: 1'b1, data: mdl[a], cyc: st + RL, addr: a};
    end
    q.push_back(e);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      done = (stall == 1'b0);
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: a=%0d got stall held %0d cycles required completion", a, n);
    end
    set_noop();
  endtask

  task automatic issue0(input int kind, input logic [6:0] a, input logic [31:0] d);
    a0 = a;
    d0 = d;
    case (kind)
      0: begin cen0 = 1'b1; wen0 = 1'b0; oen0 = 1'b0; end
      1: begin cen0 = 1'b0; wen0 = 1'b1; oen0 = 1'b1; end
      2: begin cen0 = 1'b0; wen0 = 1'b0; oen0 = 1'b1; end
      default: begin cen0 = 1'b0; wen0 = 1'b1; oen0 = 1'b0; end
    endcase
    if (kind == 3) q0.push_back(mdl0[a]);
    if (kind == 2) mdl0[a] = d;
    @(posedge clk);
    #1;
    set_noop();
  endtask

  initial begin
    int k;
    set_noop();
    A = '0; Data2Mem = '0; a0 = '0; d0 = '0;
    clear_model();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b required 0", stall);
    end
    checks++;
    if (ReadDataMem !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h required 00000000", ReadDataMem);
    end
    checks++;
    if (rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_zl_rdata: got %h required 00000000", rdata0);
    end
    @(posedge clk);
    #1;

    // Reset then read a cleared word
    do_reset();
    issue(3, 7'd5, 32'h0);

    // Write-then-read hazard
    issue(2, 7'd3, 32'hDEADBEEF);
    issue(3, 7'd3, 32'h0);

    // Back-to-back writes, then reads once the buffer has drained
    issue(2, 7'd1, 32'h11);
    issue(2, 7'd2, 32'h22);
    issue(1, 7'd0, 32'h0);
    issue(1, 7'd0, 32'h0);
    issue(3, 7'd2, 32'h0);
    issue(3, 7'd1, 32'h0);

    // No-op decodes leave the array untouched
    repeat (3) issue(1, 7'($urandom_range(0, 127)), $urandom);
    issue(0, 7'd7, 32'hFFFFFFFF);
    issue(3, 7'd7, 32'h0);

    // Reset while a write is still buffered drops it
    issue(2, 7'd9, 32'h55);
    do_reset();
    issue(1, 7'd0, 32'h0);
    issue(3, 7'd9, 32'h0);

    // Random traffic on a small address window to provoke hazards
    for (int i = 0; i < 80; i++) begin
      k = int'($urandom_range(0, 9));
      if (k < 4) issue(2, 7'($urandom_range(0, 15)), $urandom);
      else if (k < 8) issue(3, 7'($urandom_range(0, 15)), 32'h0);
      else issue(k - 8, 7'($urandom_range(0, 15)), $urandom);
    end

    // Zero-latency instance: write then immediate read
    issue0(2, 7'd127, 32'hA5A5A5A5);
    issue0(3, 7'd127, 32'h0);
    for (int i = 0; i < 30; i++) begin
      issue0(int'($urandom_range(0, 3)), 7'($urandom_range(120, 127)), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending required 0/0", q.size(), q0.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_stall_ctrl.md
# dmem_stall_ctrl

Data-memory stage placed directly downstream of the single-cycle MIPS core's data port. It consumes the core's CEN/WEN/OEN/A/Data2Mem request and returns ReadDataMem. It holds a 2^ADDR_W x DATA_W word array with configurable read and write latency, and posts writes through a one-entry write buffer. It asserts `stall` so the core freezes its PC and register write until the access completes.

## Interface
- ADDR_W, 7: word-address width; array depth 2^ADDR_W.
- DATA_W, 32: word width.
- RD_LAT, 2: read latency in cycles, range 0..7.
- WR_LAT, 2: write-buffer drain latency in cycles, range 0..7.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-high despite the name; clears all state on the clk edge where it is 1.
- CEN  in  1  chip enable, active-low.
- WEN  in  1  write enable, active-low.
- OEN  in  1  output (read) enable, active-low.
- A  in  ADDR_W  word address.
- Data2Mem  in  DATA_W  write data.
- ReadDataMem  out  DATA_W  read data.
- stall  out  1  1 = core must hold every request input and not commit this cycle.

## Operation
- Request decode:
  - Write = CEN=0 & WEN=0 (OEN ignored).
  - Read = CEN=0 & WEN=1 & OEN=0.
  - CEN=1, or CEN=0 with WEN=OEN=1: no-op, no stall, no state change.
- Core contract: request inputs stay stable while stall=1.
- Read FSM states: IDLE, RD_WAIT, RD_DONE.
  - IDLE: a read with the buffer empty sets stall=1, latches mem[A] into rdata_q, loads cnt=RD_LAT-1, and goes to RD_WAIT (or RD_DONE if RD_LAT=1).
  - RD_WAIT: stall=1; cnt decrements; at cnt=0 go to RD_DONE.
  - RD_DONE: stall=0; ReadDataMem=rdata_q; go to IDLE unconditionally. The still-present request is not re-issued.
- Write buffer: one entry {valid, addr, data, wcnt}.
  - Write in IDLE with buffer empty: stall=0; the entry is captured at the clock edge with wcnt=WR_LAT-1.
  - While valid, wcnt decrements each cycle. The commit cycle is valid & wcnt=0, and the array is written at the end of that cycle.
  - Write arriving while the buffer is valid: stall = valid & ~commit. A write present in the commit cycle is accepted with stall=0 and reloads the buffer.
  - Read arriving while the buffer is valid, including the commit cycle: stall=1. The read starts in the first IDLE cycle with the buffer empty. There is no forwarding.
- RD_LAT=0: ReadDataMem = mem[A] combinationally in the request cycle; stall never due to reads; FSM stays IDLE.
- WR_LAT=0: write goes directly to the array at the end of the request cycle; the buffer is unused.
- ReadDataMem outside RD_DONE (RD_LAT>0): holds the last rdata_q.

## Timing
- Reset values:
  - stall=0, ReadDataMem=0, FSM=IDLE.
  - Buffer invalid, cnt=wcnt=0, every array word 0.
- Read latency with buffer empty: stall high for exactly RD_LAT cycles starting in the request cycle; data valid with stall=0 in cycle t+RD_LAT.
- Posted write: zero stall cycles if the buffer is empty or committing; the array is updated at the end of cycle t+WR_LAT.
- Reset during RD_WAIT/RD_DONE or with the buffer valid:
  - The next cycle is IDLE with stall=0.
  - The pending write is dropped and the read is abandoned.
- Address is full-width; there is no out-of-range case.

## Test plan
- Reset then read: rst_n=1 for 1 cycle, then read A=5 (RD_LAT=2) at t. Required: stall=1 at t and t+1; stall=0 and ReadDataMem=0 at t+2.
- Write-then-read hazard (RD_LAT=WR_LAT=2): write 0xDEADBEEF to A=3 at t with stall=0, then read A=3 at t+1. Required: stall=1 for t+1..t+4; stall=0 and ReadDataMem=0xDEADBEEF at t+5.
- Back-to-back writes: 0x11 to A=1 at t, 0x22 to A=2 at t+1. Required: stall=1 at t+1; stall=0 at t+2, where the second write is accepted. A later read of A=1 returns 0x11; a read of A=2 issued at t+5 returns 0x22.
- No-op decode:
  - CEN=0, WEN=OEN=1 for 3 cycles: stall=0, array unchanged.
  - CEN=1, WEN=0, Data2Mem=0xFFFFFFFF, A=7: a later read of A=7 returns 0.
- Reset mid-operation: write 0x55 to A=9, then assert rst_n the next cycle during the buffered write. Required: stall=0 after reset, and a read of A=9 returns 0.
- Zero-latency build (RD_LAT=WR_LAT=0): write 0xA5A5A5A5 to A=127 at t, read A=127 at t+1. Required: ReadDataMem=0xA5A5A5A5 combinationally at t+1; stall never 1.
